// File: rtl/harmonic_sequencer_pkg.sv
// Shared definitions for the harmonic sequencer: default sizing, the FSM state
// encoding and the harmonic-to-group mapping.
package harmonic_sequencer_pkg;

  localparam int DEF_NUM_HARMONICS   = 50;
  localparam int DEF_NUM_GROUPS      = 2;
  localparam int DEF_SAMPLE_INTERVAL = 1000;
  localparam int DEF_HARM_W          = 8;
  localparam int DEF_TIMER_W         = 16;

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_SCALE      = 4'd1,
    ST_SCALE_WAIT = 4'd2,
    ST_ADD_START  = 4'd3,
    ST_ADD_WAIT   = 4'd4,
    ST_NEXT       = 4'd5,
    ST_DONE       = 4'd6,
    ST_WAIT_TICK  = 4'd7
  } state_e;

  // Harmonics are dealt round-robin over the adder/scaler groups.
  function automatic int unsigned harm_group(input int unsigned harmonic,
                                             input int unsigned num_groups);
    return harmonic % num_groups;
  endfunction

endpackage

// File: rtl/harmonic_sequencer_if.sv
// Control bus between the harmonic sequencer and its lookup, scaler, adder and
// DAC neighbours. The sequencer sits on the master side.
interface harmonic_sequencer_if
  import harmonic_sequencer_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int HARM_W     = DEF_HARM_W
);

  logic [HARM_W-1:0]     i_Harmonic_Count;
  logic [NUM_GROUPS-1:0] i_Mute;
  logic                  i_Sample_Ready;
  logic                  i_Freq_Too_High;
  logic [NUM_GROUPS-1:0] i_Scaler_Ready;

  logic [HARM_W-1:0]     o_Harmonic;
  logic                  o_Next_Sample;
  logic [NUM_GROUPS-1:0] o_Scaler_Start;
  logic                  o_Scaler_Reset;
  logic [NUM_GROUPS-1:0] o_Adder_Start;
  logic                  o_Adder_Clear;
  logic                  o_Latch;
  logic                  o_DAC_Send;
  logic                  o_Overrun;
  logic                  o_Busy;

  modport master (
    input  i_Harmonic_Count, i_Mute, i_Sample_Ready, i_Freq_Too_High, i_Scaler_Ready,
    output o_Harmonic, o_Next_Sample, o_Scaler_Start, o_Scaler_Reset, o_Adder_Start,
           o_Adder_Clear, o_Latch, o_DAC_Send, o_Overrun, o_Busy
  );

  modport slave (
    output i_Harmonic_Count, i_Mute, i_Sample_Ready, i_Freq_Too_High, i_Scaler_Ready,
    input  o_Harmonic, o_Next_Sample, o_Scaler_Start, o_Scaler_Reset, o_Adder_Start,
           o_Adder_Clear, o_Latch, o_DAC_Send, o_Overrun, o_Busy
  );

endinterface

// File: rtl/harmonic_sequencer_tick_timer.sv
// Free-running output sample timer; o_Tick is high for the single cycle in
// which the count sits on its last value.
module sample_tick_timer
  import harmonic_sequencer_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
  parameter int TIMER_W         = DEF_TIMER_W
) (
  input  logic Main_Clock,
  input  logic Reset,
  output logic o_Tick
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(SAMPLE_INTERVAL - 1);

  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      r_timer <= '0;
    end else if (r_timer == LAST_COUNT) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_Tick = (r_timer == LAST_COUNT);

endmodule

// File: rtl/harmonic_sequencer.sv
// Frame sequencer: walks harmonics 0..L-1 through the scaler/adder groups,
// then latches the totals and hands them to the DAC on the next sample tick.
module harmonic_sequencer
  import harmonic_sequencer_pkg::*;
#(
  parameter int NUM_HARMONICS   = DEF_NUM_HARMONICS,
  parameter int NUM_GROUPS      = DEF_NUM_GROUPS,
  parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
  parameter int HARM_W          = DEF_HARM_W,
  parameter int TIMER_W         = DEF_TIMER_W
) (
  input  logic                 Main_Clock,
  input  logic                 Reset,
  harmonic_sequencer_if.master bus
);

  localparam logic [HARM_W-1:0] MAX_HARM  = HARM_W'(NUM_HARMONICS);
  localparam logic [HARM_W:0]   GROUPS_WX = (HARM_W + 1)'(NUM_GROUPS);

  state_e                r_state;
  logic [HARM_W-1:0]     r_harmonic;
  logic [HARM_W-1:0]     r_limit;
  logic [NUM_GROUPS-1:0] r_scaler_start;
  logic [NUM_GROUPS-1:0] r_adder_start;
  logic                  r_next_sample;
  logic                  r_scaler_reset;
  logic                  r_adder_clear;
  logic                  r_latch;
  logic                  r_dac_send;
  logic                  r_overrun;
  logic                  r_busy;

  logic                  w_tick;
  logic [HARM_W:0]       w_harm_inc;
  logic [HARM_W-1:0]     w_limit;
  int unsigned           w_cur_group;
  int unsigned           w_inc_group;
  logic [NUM_GROUPS-1:0] w_cur_onehot;
  logic [NUM_GROUPS-1:0] w_inc_onehot;

  sample_tick_timer #(
    .SAMPLE_INTERVAL (SAMPLE_INTERVAL),
    .TIMER_W         (TIMER_W)
  ) u_tick_timer (
    .Main_Clock (Main_Clock),
    .Reset      (Reset),
    .o_Tick     (w_tick)
  );

  // One extra bit so the index+1 compare never wraps.
  assign w_harm_inc  = {1'b0, r_harmonic} + 1'b1;
  assign w_cur_group = harm_group(32'(r_harmonic), NUM_GROUPS);
  assign w_inc_group = harm_group(32'(w_harm_inc), NUM_GROUPS);

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
    assign w_cur_onehot[gi] = (w_cur_group == unsigned'(gi));
    assign w_inc_onehot[gi] = (w_inc_group == unsigned'(gi));
  end

  always_comb begin
    w_limit = bus.i_Harmonic_Count;
    if (bus.i_Harmonic_Count == '0) begin
      w_limit = HARM_W'(1);
    end else if (bus.i_Harmonic_Count > MAX_HARM) begin
      w_limit = MAX_HARM;
    end
  end

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      r_state        <= ST_INIT;
      r_harmonic     <= '0;
      r_limit        <= HARM_W'(1);
      r_scaler_start <= '0;
      r_adder_start  <= '0;
      r_next_sample  <= 1'b0;
      r_scaler_reset <= 1'b0;
      r_adder_clear  <= 1'b0;
      r_latch        <= 1'b0;
      r_dac_send     <= 1'b0;
      r_overrun      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_scaler_start <= '0;
      r_adder_start  <= '0;
      r_next_sample  <= 1'b0;
      r_scaler_reset <= 1'b0;
      r_adder_clear  <= 1'b0;
      r_latch        <= 1'b0;
      r_dac_send     <= 1'b0;
      r_overrun      <= w_tick && (r_state != ST_WAIT_TICK);
      r_busy         <= 1'b1;

      case (r_state)
        ST_INIT: begin
          r_harmonic <= '0;
          r_limit    <= w_limit;
          r_state    <= ST_ADD_START;
        end
        ST_SCALE: begin
          r_state <= ST_SCALE_WAIT;
        end
        ST_SCALE_WAIT: begin
          if (|(bus.i_Scaler_Ready & w_cur_onehot)) begin
            r_state <= ST_ADD_START;
          end
        end
        ST_ADD_START: begin
          if (bus.i_Sample_Ready) begin
            r_adder_start <= w_cur_onehot & ~bus.i_Mute;
            r_state       <= ST_ADD_WAIT;
          end
        end
        ST_ADD_WAIT: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          r_harmonic    <= w_harm_inc[HARM_W-1:0];
          r_next_sample <= 1'b1;
          if ((w_harm_inc >= {1'b0, r_limit}) || bus.i_Freq_Too_High) begin
            r_state <= ST_DONE;
            r_latch <= 1'b1;
          end else if (w_harm_inc >= GROUPS_WX) begin
            // Later harmonics of a group need the scaler stepped first.
            r_state        <= ST_SCALE;
            r_scaler_start <= w_inc_onehot;
          end else begin
            r_state <= ST_ADD_START;
          end
        end
        ST_DONE: begin
          r_adder_clear <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          r_busy <= 1'b0;
          if (w_tick) begin
            r_dac_send     <= 1'b1;
            r_scaler_reset <= 1'b1;
            r_next_sample  <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_INIT;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.o_Harmonic     = r_harmonic;
  assign bus.o_Next_Sample  = r_next_sample;
  assign bus.o_Scaler_Start = r_scaler_start;
  assign bus.o_Scaler_Reset = r_scaler_reset;
  assign bus.o_Adder_Start  = r_adder_start;
  assign bus.o_Adder_Clear  = r_adder_clear;
  assign bus.o_Latch        = r_latch;
  assign bus.o_DAC_Send     = r_dac_send;
  assign bus.o_Overrun      = r_overrun;
  assign bus.o_Busy         = r_busy;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer: a slow-tick instance for frame
// sequencing and a fast-tick instance for overrun behaviour.
module tb_harmonic_sequencer;

  logic Main_Clock = 1'b0;
  logic Reset;
  logic Fast_Reset;
  int   checks = 0;
  int   passes = 0;

  harmonic_sequencer_if #(.NUM_GROUPS(2), .HARM_W(8)) sb();
  harmonic_sequencer_if #(.NUM_GROUPS(2), .HARM_W(8)) fb();

  harmonic_sequencer #(
    .NUM_HARMONICS(50), .NUM_GROUPS(2), .SAMPLE_INTERVAL(1000), .HARM_W(8), .TIMER_W(16)
  ) u_slow (
    .Main_Clock (Main_Clock),
    .Reset      (Reset),
    .bus        (sb)
  );

  harmonic_sequencer #(
    .NUM_HARMONICS(50), .NUM_GROUPS(2), .SAMPLE_INTERVAL(20), .HARM_W(8), .TIMER_W(16)
  ) u_fast (
    .Main_Clock (Main_Clock),
    .Reset      (Fast_Reset),
    .bus        (fb)
  );

  always #5 Main_Clock = ~Main_Clock;

  // Observations gathered by run_slow, counted from reset release (edge 1).
  int         latch_n, latch_cnt, clear_n, clear_cnt, next_cnt, dac_n, ovr_cnt, harm_at_latch;
  logic       busy_at_latch, busy_after_latch;
  logic [1:0] dac_aux;
  logic [1:0] add_q[$];
  logic [1:0] scl_q[$];
  int         scl_h_q[$];
  logic [7:0] seq;
  logic [15:0] hseq;

  task automatic set_inputs(input logic [7:0] count, input logic [1:0] mute,
                            input logic [1:0] scl_rdy);
    sb.i_Harmonic_Count = count;
    sb.i_Mute           = mute;
    sb.i_Sample_Ready   = 1'b1;
    sb.i_Freq_Too_High  = 1'b0;
    sb.i_Scaler_Ready   = scl_rdy;
  endtask

  task automatic slow_reset();
    Reset = 1'b1;
    @(posedge Main_Clock); #1;
    @(posedge Main_Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic run_slow(input int cycles, input int freq_h);
    latch_n = 0; latch_cnt = 0; clear_n = 0; clear_cnt = 0; next_cnt = 0;
    dac_n = 0; ovr_cnt = 0; harm_at_latch = -1; dac_aux = 2'b00;
    busy_at_latch = 1'bx; busy_after_latch = 1'bx;
    add_q.delete(); scl_q.delete(); scl_h_q.delete();
    for (int n = 1; n <= cycles; n++) begin
      @(posedge Main_Clock); #1;
      if (sb.o_Latch) begin
        latch_cnt++;
        if (latch_n == 0) begin
          latch_n       = n;
          harm_at_latch = int'(sb.o_Harmonic);
          busy_at_latch = sb.o_Busy;
        end
      end
      if (latch_n != 0 && n == latch_n + 1) busy_after_latch = sb.o_Busy;
      if (sb.o_Adder_Clear) begin
        clear_cnt++;
        if (clear_n == 0) clear_n = n;
      end
      if (sb.o_Next_Sample && (latch_n == 0 || n == latch_n)) next_cnt++;
      if (sb.o_DAC_Send && dac_n == 0) begin
        dac_n   = n;
        dac_aux = {sb.o_Scaler_Reset, sb.o_Next_Sample};
      end
      if (sb.o_Overrun) ovr_cnt++;
      if (sb.o_Adder_Start != 2'b00) add_q.push_back(sb.o_Adder_Start);
      if (sb.o_Scaler_Start != 2'b00) begin
        scl_q.push_back(sb.o_Scaler_Start);
        scl_h_q.push_back(int'(sb.o_Harmonic));
      end
      sb.i_Freq_Too_High = (freq_h >= 0) && (int'(sb.o_Harmonic) == freq_h);
    end
    sb.i_Freq_Too_High = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(8'd4, 2'b00, 2'b11);
    fb.i_Harmonic_Count = 8'd50; fb.i_Mute = 2'b00; fb.i_Sample_Ready = 1'b0;
    fb.i_Freq_Too_High = 1'b0; fb.i_Scaler_Ready = 2'b11;
    Reset = 1'b1; Fast_Reset = 1'b1;
    @(posedge Main_Clock); #1;
    @(posedge Main_Clock); #1;
    checks++;
    if ({sb.o_Next_Sample, sb.o_Scaler_Start, sb.o_Scaler_Reset, sb.o_Adder_Start, sb.o_Adder_Clear,
         sb.o_Latch, sb.o_DAC_Send, sb.o_Overrun, sb.o_Busy} !== 11'd0)
      $display("FAIL reset_outputs: got %b expected all zero", {sb.o_Next_Sample, sb.o_Scaler_Start,
               sb.o_Scaler_Reset, sb.o_Adder_Start, sb.o_Adder_Clear, sb.o_Latch, sb.o_DAC_Send,
               sb.o_Overrun, sb.o_Busy});
    else passes++;
    checks++;
    if (sb.o_Harmonic !== 8'd0) $display("FAIL reset_harmonic: got %0d expected 0", sb.o_Harmonic);
    else passes++;
    checks++;
    if ({fb.o_Latch, fb.o_DAC_Send, fb.o_Overrun, fb.o_Busy, fb.o_Adder_Start} !== 6'd0)
      $display("FAIL reset_fast_outputs: got %b expected all zero",
               {fb.o_Latch, fb.o_DAC_Send, fb.o_Overrun, fb.o_Busy, fb.o_Adder_Start});
    else passes++;
  endtask

  task automatic test_basic_frame();
    set_inputs(8'd4, 2'b00, 2'b11);
    slow_reset();
    run_slow(40, -1);
    checks++; if (latch_n !== 17) $display("FAIL basic_latch_cycle: got %0d expected 17", latch_n); else passes++;
    checks++; if (latch_cnt !== 1) $display("FAIL basic_latch_count: got %0d expected 1", latch_cnt); else passes++;
    checks++; if (clear_n !== 18) $display("FAIL basic_clear_cycle: got %0d expected 18", clear_n); else passes++;
    checks++; if (harm_at_latch !== 4) $display("FAIL basic_harmonic_end: got %0d expected 4", harm_at_latch); else passes++;
    checks++; if (busy_at_latch !== 1'b1) $display("FAIL basic_busy_done: got %b expected 1", busy_at_latch); else passes++;
    checks++; if (busy_after_latch !== 1'b0) $display("FAIL basic_busy_wait: got %b expected 0", busy_after_latch); else passes++;
    checks++; if (next_cnt !== 4) $display("FAIL basic_next_sample: got %0d expected 4", next_cnt); else passes++;
    seq = '0;
    foreach (add_q[i]) seq = {seq[5:0], add_q[i]};
    checks++;
    if (add_q.size() != 4 || seq !== 8'b01_10_01_10)
      $display("FAIL basic_adder_order: got %0d pulses seq %b expected 4 pulses seq 01100110", add_q.size(), seq);
    else passes++;
    seq = '0; hseq = '0;
    foreach (scl_q[i]) begin
      seq  = {seq[5:0], scl_q[i]};
      hseq = {hseq[7:0], 8'(scl_h_q[i])};
    end
    checks++;
    if (scl_q.size() != 2 || seq !== 8'b0000_01_10 || hseq !== {8'd2, 8'd3})
      $display("FAIL basic_scaler_steps: got %0d pulses masks %b harmonics %h expected 2 pulses masks 0110 harmonics 0203",
               scl_q.size(), seq, hseq);
    else passes++;
  endtask

  task automatic test_mute();
    set_inputs(8'd6, 2'b10, 2'b11);
    slow_reset();
    run_slow(60, -1);
    checks++; if (latch_n !== 27) $display("FAIL mute_latch_cycle: got %0d expected 27", latch_n); else passes++;
    seq = '0;
    foreach (add_q[i]) seq = {seq[5:0], add_q[i]};
    checks++;
    if (add_q.size() != 3 || seq !== 8'b00_01_01_01)
      $display("FAIL mute_adder_starts: got %0d pulses seq %b expected 3 pulses seq 010101", add_q.size(), seq);
    else passes++;
    checks++; if (next_cnt !== 6) $display("FAIL mute_next_sample: got %0d expected 6", next_cnt); else passes++;
    seq = '0;
    foreach (scl_q[i]) seq = {seq[5:0], scl_q[i]};
    checks++;
    if (scl_q.size() != 4 || seq !== 8'b01_10_01_10)
      $display("FAIL mute_scaler_steps: got %0d pulses seq %b expected 4 pulses seq 01100110", scl_q.size(), seq);
    else passes++;
  endtask

  task automatic test_freq_high();
    set_inputs(8'd50, 2'b00, 2'b11);
    slow_reset();
    run_slow(60, 5);
    checks++; if (latch_n !== 27) $display("FAIL freq_latch_cycle: got %0d expected 27", latch_n); else passes++;
    checks++; if (add_q.size() !== 6) $display("FAIL freq_adder_count: got %0d expected 6", add_q.size()); else passes++;
    checks++; if (harm_at_latch !== 6) $display("FAIL freq_harmonic_end: got %0d expected 6", harm_at_latch); else passes++;
  endtask

  task automatic test_coincide();
    set_inputs(8'd6, 2'b00, 2'b11);
    slow_reset();
    run_slow(60, 5);
    checks++; if (latch_cnt !== 1) $display("FAIL coincide_latch_count: got %0d expected 1", latch_cnt); else passes++;
    checks++; if (clear_cnt !== 1) $display("FAIL coincide_clear_count: got %0d expected 1", clear_cnt); else passes++;
    checks++; if (latch_n !== 27) $display("FAIL coincide_latch_cycle: got %0d expected 27", latch_n); else passes++;
  endtask

  task automatic test_limits();
    set_inputs(8'd0, 2'b00, 2'b11);
    slow_reset();
    run_slow(30, -1);
    checks++; if (latch_n !== 4) $display("FAIL limit0_latch_cycle: got %0d expected 4", latch_n); else passes++;
    checks++; if (add_q.size() !== 1) $display("FAIL limit0_adder_count: got %0d expected 1", add_q.size()); else passes++;
    set_inputs(8'd255, 2'b00, 2'b11);
    slow_reset();
    run_slow(300, -1);
    checks++; if (latch_n !== 247) $display("FAIL limit255_latch_cycle: got %0d expected 247", latch_n); else passes++;
    checks++; if (add_q.size() !== 50) $display("FAIL limit255_adder_count: got %0d expected 50", add_q.size()); else passes++;
    checks++; if (harm_at_latch !== 50) $display("FAIL limit255_harmonic_end: got %0d expected 50", harm_at_latch); else passes++;
    checks++; if (ovr_cnt !== 0) $display("FAIL limit255_overrun: got %0d expected 0", ovr_cnt); else passes++;
  endtask

  task automatic test_reset_midframe();
    int scl_n;
    scl_n = 0;
    set_inputs(8'd4, 2'b00, 2'b00);
    slow_reset();
    for (int n = 1; n <= 20; n++) begin
      @(posedge Main_Clock); #1;
      if (sb.o_Scaler_Start != 2'b00) begin
        scl_n = n;
        break;
      end
    end
    checks++; if (scl_n !== 7) $display("FAIL midreset_scale_cycle: got %0d expected 7", scl_n); else passes++;
    @(posedge Main_Clock); #1;
    Reset = 1'b1;
    @(posedge Main_Clock); #1;
    checks++;
    if ({sb.o_Next_Sample, sb.o_Scaler_Start, sb.o_Scaler_Reset, sb.o_Adder_Start, sb.o_Adder_Clear,
         sb.o_Latch, sb.o_DAC_Send, sb.o_Overrun, sb.o_Busy, sb.o_Harmonic} !== 19'd0)
      $display("FAIL midreset_outputs: got %b expected all zero", {sb.o_Next_Sample, sb.o_Scaler_Start,
               sb.o_Scaler_Reset, sb.o_Adder_Start, sb.o_Adder_Clear, sb.o_Latch, sb.o_DAC_Send,
               sb.o_Overrun, sb.o_Busy, sb.o_Harmonic});
    else passes++;
    sb.i_Scaler_Ready = 2'b11;
    Reset = 1'b0;
    run_slow(1010, -1);
    checks++; if (latch_n !== 17) $display("FAIL midreset_latch_cycle: got %0d expected 17", latch_n); else passes++;
    checks++; if (dac_n !== 1000) $display("FAIL midreset_dac_cycle: got %0d expected 1000", dac_n); else passes++;
    checks++; if (dac_aux !== 2'b11) $display("FAIL midreset_dac_companions: got %b expected 11", dac_aux); else passes++;
  endtask

  task automatic test_overrun();
    int f_latch, f_dac, f_ovr, f_bad, exp_dac;
    f_latch = 0; f_dac = 0; f_ovr = 0; f_bad = 0;
    @(posedge Main_Clock); #1;
    Fast_Reset = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge Main_Clock); #1;
      if (fb.o_Latch && f_latch == 0) f_latch = n;
      if (fb.o_Overrun) begin
        f_ovr++;
        if (n % 20 != 0) f_bad++;
      end
      if (fb.o_DAC_Send) begin
        f_dac = n;
        break;
      end
      fb.i_Sample_Ready = ((n % 6) == 5);
    end
    // DONE occupies the cycle after the latch, so the first usable tick edge is latch+2.
    exp_dac = ((f_latch + 2 + 19) / 20) * 20;
    checks++; if (f_latch == 0) $display("FAIL overrun_latch_seen: got %0d expected nonzero", f_latch); else passes++;
    checks++; if (f_dac !== exp_dac) $display("FAIL overrun_dac_cycle: got %0d expected %0d", f_dac, exp_dac); else passes++;
    checks++;
    if (f_ovr !== (f_latch + 1) / 20 || f_ovr < 1)
      $display("FAIL overrun_count: got %0d expected %0d", f_ovr, (f_latch + 1) / 20);
    else passes++;
    checks++; if (f_bad !== 0) $display("FAIL overrun_alignment: got %0d misplaced expected 0", f_bad); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mute();
    test_freq_high();
    test_coincide();
    test_limits();
    test_reset_midframe();
    test_overrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
